// File: rtl/equ_pkg.sv
// Shared types and sizes for the channel-equalization RAM sequencer.
// Holds the FSM state type and the RAM geometry.
package equ_pkg;

  localparam int N_SC              = 12;
  localparam int ADDR_W            = 4;
  localparam int DOUBLE_DATA_WIDTH = 32;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    WAIT_DATA,
    READ,
    DONE
  } equ_ctrl_state_t;

endpackage

// File: rtl/equ_ram_ctrl.sv
// Fill/read sequencer for the 12x32 equalization RAM (NB-IoT UL RX).
// Optional sticky protocol-error flag: define EQU_CTRL_ERR_EN.
module equ_ram_ctrl
  import equ_pkg::*;
(
  input  logic                         i_clk_equ_ctrl,
  input  logic                         i_rst_equ_ctrl,
  input  logic                         i_start,
  input  logic [3:0]                   i_num_sym,
  input  logic                         i_est_valid,
  input  logic [DOUBLE_DATA_WIDTH-1:0] i_est_data,
  input  logic                         i_sym_valid,
  input  logic [DOUBLE_DATA_WIDTH-1:0] i_sym_data,
  input  logic [DOUBLE_DATA_WIDTH-1:0] i_ram_rd_data,
  output logic                         o_ram_wr_en,
  output logic [ADDR_W-1:0]            o_ram_wr_add,
  output logic [DOUBLE_DATA_WIDTH-1:0] o_ram_wr_data,
  output logic [ADDR_W-1:0]            o_ram_rd_add,
  output logic                         o_pair_valid,
  output logic [DOUBLE_DATA_WIDTH-1:0] o_y,
  output logic [DOUBLE_DATA_WIDTH-1:0] o_h,
  output logic                         o_h_ready,
  output logic                         o_done,
  output logic                         o_err
);

  localparam logic [ADDR_W-1:0] LAST_SC = ADDR_W'(N_SC - 1);

  equ_ctrl_state_t state;

  logic [ADDR_W-1:0]            wr_cnt;
  logic [ADDR_W-1:0]            sc_cnt;
  logic [3:0]                   sym_cnt;
  logic [3:0]                   num_sym;
  logic                         pair_q;
  logic [DOUBLE_DATA_WIDTH-1:0] y_q;

  logic in_fill;
  logic in_rx;
  logic wr_ok;
  logic rd_ok;

  assign in_fill = (state == FILL);
  assign in_rx   = (state == WAIT_DATA) || (state == READ);
  assign wr_ok   = in_fill && i_est_valid;
  assign rd_ok   = in_rx && i_sym_valid;

  always_ff @(posedge i_clk_equ_ctrl) begin
    if (i_rst_equ_ctrl) begin
      state   <= IDLE;
      wr_cnt  <= '0;
      sc_cnt  <= '0;
      sym_cnt <= '0;
      num_sym <= '0;
      pair_q  <= 1'b0;
      y_q     <= '0;
    end else begin
      pair_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (i_start) begin
            state   <= FILL;
            wr_cnt  <= '0;
            sc_cnt  <= '0;
            sym_cnt <= '0;
            num_sym <= (i_num_sym == 4'd0) ? 4'd1 : i_num_sym;
          end
        end
        FILL: begin
          if (i_est_valid) begin
            if (wr_cnt == LAST_SC) begin
              state  <= WAIT_DATA;
              wr_cnt <= '0;
            end else begin
              wr_cnt <= wr_cnt + 1'b1;
            end
          end
        end
        WAIT_DATA, READ: begin
          if (i_sym_valid) begin
            pair_q <= 1'b1;
            y_q    <= i_sym_data;
            state  <= READ;
            if (sc_cnt == LAST_SC) begin
              sc_cnt <= '0;
              if (sym_cnt == num_sym - 4'd1) begin
                state <= DONE;
              end else begin
                sym_cnt <= sym_cnt + 4'd1;
              end
            end else begin
              sc_cnt <= sc_cnt + 1'b1;
            end
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef EQU_CTRL_ERR_EN
  logic err_q;
  logic viol;

  assign viol = (i_est_valid && !in_fill) ||
                (i_sym_valid && !in_rx) ||
                (i_start && (state != IDLE));

  // A violation in the same cycle as an accepted start still sets the flag.
  always_ff @(posedge i_clk_equ_ctrl) begin
    if (i_rst_equ_ctrl) begin
      err_q <= 1'b0;
    end else if (viol) begin
      err_q <= 1'b1;
    end else if (i_start && (state == IDLE)) begin
      err_q <= 1'b0;
    end
  end

  assign o_err = err_q;
`else
  assign o_err = 1'b0;
`endif

  assign o_ram_wr_en   = wr_ok;
  assign o_ram_wr_add  = wr_ok ? wr_cnt : '0;
  assign o_ram_wr_data = wr_ok ? i_est_data : '0;
  assign o_ram_rd_add  = rd_ok ? sc_cnt : '0;

  assign o_pair_valid  = pair_q;
  assign o_y           = y_q;
  assign o_h           = pair_q ? i_ram_rd_data : '0;
  assign o_h_ready     = in_rx;
  assign o_done        = (state == DONE);

endmodule

// File: tb/tb_equ_ram_ctrl.sv
// Randomized self-checking bench for equ_ram_ctrl with a queue-based pair model.
// Honours EQU_CTRL_ERR_EN for the expected o_err behaviour.
module tb_equ_ram_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  num_sym;
  logic        est_valid;
  logic [31:0] est_data;
  logic        sym_valid;
  logic [31:0] sym_data;
  logic [31:0] ram_rd_data;
  logic        ram_wr_en;
  logic [3:0]  ram_wr_add;
  logic [31:0] ram_wr_data;
  logic [3:0]  ram_rd_add;
  logic        pair_valid;
  logic [31:0] y;
  logic [31:0] h;
  logic        h_ready;
  logic        done;
  logic        err;

  equ_ram_ctrl dut (
    .i_clk_equ_ctrl (clk),
    .i_rst_equ_ctrl (rst),
    .i_start        (start),
    .i_num_sym      (num_sym),
    .i_est_valid    (est_valid),
    .i_est_data     (est_data),
    .i_sym_valid    (sym_valid),
    .i_sym_data     (sym_data),
    .i_ram_rd_data  (ram_rd_data),
    .o_ram_wr_en    (ram_wr_en),
    .o_ram_wr_add   (ram_wr_add),
    .o_ram_wr_data  (ram_wr_data),
    .o_ram_rd_add   (ram_rd_add),
    .o_pair_valid   (pair_valid),
    .o_y            (y),
    .o_h            (h),
    .o_h_ready      (h_ready),
    .o_done         (done),
    .o_err          (err)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:15];
  always @(posedge clk) begin
    if (ram_wr_en) mem[ram_wr_add] <= ram_wr_data;
    ram_rd_data <= mem[ram_rd_add];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          at;
    logic [31:0] y;
    logic [31:0] h;
    bit          last;
  } exp_t;

  exp_t exq[$];

  int n_tests = 0;
  int n_fail  = 0;

`ifdef EQU_CTRL_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] est_val(input int i);
    return 32'(i + 1) << 16;
  endfunction

  // Pair monitor: every cycle either exactly one expected pair or none.
  always @(negedge clk) begin
    if (!rst) begin
      bit ev;
      exp_t e;
      ev = (exq.size() > 0) && (exq[0].at == cyc);
      check("pair_valid", 32'(pair_valid), 32'(ev));
      if (ev) begin
        e = exq.pop_front();
        check("pair_y", y, e.y);
        check("pair_h", h, e.h);
        check("pair_done", 32'(done), 32'(e.last));
      end else begin
        check("done_idle", 32'(done), 32'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b1;
    start = 1'b0;
    est_valid = 1'b0;
    sym_valid = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    check("rst_pair", 32'(pair_valid), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ready", 32'(h_ready), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_wren", 32'(ram_wr_en), 32'd0);
    tick();
    rst = 1'b0;
  endtask

  task automatic start_slot(input logic [3:0] n);
    tick();
    start = 1'b1;
    num_sym = n;
    tick();
    start = 1'b0;
    num_sym = $urandom_range(0, 15);
    @(negedge clk);
    check("start_err_clr", 32'(err), 32'd0);
    check("start_ready", 32'(h_ready), 32'd0);
  endtask

  task automatic fill(input bit inject);
    for (int i = 0; i < 12; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        tick();
        est_valid = 1'b0;
        @(negedge clk);
        check("fill_gap_wren", 32'(ram_wr_en), 32'd0);
      end
      if (inject && i == 3) begin
        tick();
        est_valid = 1'b0;
        sym_valid = 1'b1;
        sym_data = $urandom;
        @(negedge clk);
        check("bad_sym_wren", 32'(ram_wr_en), 32'd0);
        check("bad_sym_rdadd", 32'(ram_rd_add), 32'd0);
        tick();
        sym_valid = 1'b0;
        @(negedge clk);
        check("err_set", 32'(err), 32'(ERR_EN));
      end
      tick();
      est_valid = 1'b1;
      est_data = est_val(i);
      @(negedge clk);
      check("fill_wren", 32'(ram_wr_en), 32'd1);
      check("fill_wradd", 32'(ram_wr_add), 32'(i));
      check("fill_wrdata", ram_wr_data, est_val(i));
      check("fill_ready", 32'(h_ready), 32'd0);
    end
    tick();
    est_valid = 1'b0;
    @(negedge clk);
    check("ready_after_fill", 32'(h_ready), 32'd1);
    check("err_after_fill", 32'(err), 32'(ERR_EN && inject));
  endtask

  task automatic send_syms(input int n, input bit gaps, input int stop);
    int total;
    int limit;
    exp_t e;
    total = 12 * ((n == 0) ? 1 : n);
    limit = (stop > 0) ? stop : total;
    for (int k = 0; k < limit; k++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 3)) begin
          tick();
          sym_valid = 1'b0;
        end
      end
      tick();
      sym_valid = 1'b1;
      sym_data = $urandom;
      e.at = cyc + 1;
      e.y = sym_data;
      e.h = est_val(k % 12);
      e.last = (k == total - 1);
      exq.push_back(e);
    end
    tick();
    sym_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 8 && exq.size() > 0; i++) @(negedge clk);
    check("drain", 32'(exq.size()), 32'd0);
  endtask

  task automatic check_idle();
    repeat (2) tick();
    @(negedge clk);
    check("idle_ready", 32'(h_ready), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    num_sym = 4'd0;
    est_valid = 1'b0;
    est_data = '0;
    sym_valid = 1'b0;
    sym_data = '0;
    for (int i = 0; i < 16; i++) mem[i] = '0;

    do_reset();

    start_slot(4'd2);
    fill(1'b0);
    send_syms(2, 1'b0, 0);
    drain();
    check_idle();

    start_slot(4'd2);
    fill(1'b0);
    send_syms(2, 1'b1, 0);
    drain();
    check_idle();

    start_slot(4'd0);
    fill(1'b0);
    send_syms(0, 1'b1, 0);
    drain();
    check_idle();

    start_slot(4'd2);
    fill(1'b0);
    send_syms(2, 1'b0, 5);
    drain();
    do_reset();
    start_slot(4'd1);
    fill(1'b0);
    send_syms(1, 1'b1, 0);
    drain();
    check_idle();

    start_slot(4'd1);
    fill(1'b1);
    send_syms(1, 1'b0, 0);
    drain();
    check_idle();
    check("err_sticky", 32'(err), 32'(ERR_EN));
    start_slot(4'd3);
    fill(1'b0);
    send_syms(3, 1'b1, 0);
    drain();
    check_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

endmodule
